// File: rtl/inert_pkg.sv
// -----------------------------------------------------------------------------
// inert_pkg
// Shared types and constants for the inertial-sensor sequencer.
//   inert_state_t : sequencer state encoding (also exported on a debug port)
//   CFG_CMD0..2   : configuration writes, issued in index order after power-up
//   CMD_YL/CMD_YH : yaw-rate low/high byte reads (register address | read bit)
//   NUM_CFG       : number of configuration writes
//   cfg_cmd()     : index -> configuration command lookup
// -----------------------------------------------------------------------------
package inert_pkg;

   typedef enum logic [2:0] {
      PWRUP  = 3'd0,
      CFG    = 3'd1,
      CFG_W  = 3'd2,
      IDLE   = 3'd3,
      RD_L   = 3'd4,
      RD_L_W = 3'd5,
      RD_H   = 3'd6,
      RD_H_W = 3'd7
   } inert_state_t;

   localparam int          NUM_CFG  = 3;
   localparam logic [15:0] CFG_CMD0 = 16'h0D02;  // INT on gyro data ready
   localparam logic [15:0] CFG_CMD1 = 16'h1160;  // gyro ODR 416 Hz
   localparam logic [15:0] CFG_CMD2 = 16'h1440;  // rounding
   localparam logic [15:0] CMD_YL   = 16'hA600;  // reg 0x26 | read
   localparam logic [15:0] CMD_YH   = 16'hA700;  // reg 0x27 | read

   function automatic logic [15:0] cfg_cmd(input logic [1:0] idx);
      logic [15:0] cmd;
      case (idx)
         2'd0:    cmd = CFG_CMD0;
         2'd1:    cmd = CFG_CMD1;
         default: cmd = CFG_CMD2;
      endcase
      return cmd;
   endfunction

endpackage

// File: rtl/inert_ctrl_if.sv
// -----------------------------------------------------------------------------
// inert_ctrl_if
// Request channel between the sequencer (master) and the SPI monarch (slave).
//   spi_wrt     : one-cycle transaction start pulse (master -> slave)
//   spi_cmd     : 16-bit command word for the monarch's wt_data (master -> slave)
//   spi_done    : monarch done level (slave -> master)
//   spi_rd_data : monarch read data, only [7:0] carries the register byte
//
// Handshake: the master pulses spi_wrt for one cycle only while no transaction
// is outstanding, with spi_cmd loaded in that same cycle and held stable until
// completion. The slave drops spi_done after accepting spi_wrt and raises it
// at the end of the transaction; only the low-to-high transition of spi_done
// marks completion, a level left high from an earlier transfer never does.
// spi_rd_data is valid at that rising edge.
// -----------------------------------------------------------------------------
interface inert_ctrl_if;
   logic        spi_wrt;
   logic [15:0] spi_cmd;
   logic        spi_done;
   logic [15:0] spi_rd_data;

   modport master (
      output spi_wrt,
      output spi_cmd,
      input  spi_done,
      input  spi_rd_data
   );

   modport slave (
      input  spi_wrt,
      input  spi_cmd,
      output spi_done,
      output spi_rd_data
   );
endinterface

// File: rtl/inert_int_sync.sv
// -----------------------------------------------------------------------------
// inert_int_sync
// Two-flop synchroniser plus rising-edge detect for an asynchronous strobe.
// Usable for any async sensor strobe, not only the data-ready interrupt.
//   clk      in  : destination clock
//   rst_n    in  : asynchronous active-low reset
//   async_in in  : asynchronous input strobe
//   rise     out : one-cycle pulse on a synchronised 0->1 transition
// -----------------------------------------------------------------------------
module inert_int_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic rise
);

   // [0],[1] are the synchroniser stages, [2] holds the previous synced value
   logic [2:0] sync_q, sync_d;

   always_comb begin
      sync_d = {sync_q[1:0], async_in};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 3'b000;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/inert_ctrl.sv
// -----------------------------------------------------------------------------
// inert_ctrl
// Sequencer for the SPI monarch talking to the inertial sensor. Waits for
// sensor power-up, writes the configuration table, then services each
// data-ready interrupt by reading the yaw-rate low and high bytes and
// presenting the 16-bit result with a one-cycle valid pulse.
//
// Parameters:
//   PWRUP_W : power-up counter width; first command issues 2^PWRUP_W clocks
//             after reset release
//   TMO_W   : transaction watchdog width (only with INERT_TMO_EN)
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   INT        : asynchronous active-high sensor data-ready
//   spi        : master side of inert_ctrl_if (spi_wrt, spi_cmd, spi_done,
//                spi_rd_data)
//   yaw_rt     : signed yaw rate {high byte, low byte}
//   vld        : one-cycle pulse, yaw_rt updated
//   cfg_done   : level, configuration complete
//   err        : sticky watchdog error flag
//   state      : debug view of the sequencer state
//
// Build option: define INERT_TMO_EN to add the transaction watchdog. When it
// expires an outstanding transfer is abandoned and err is set; without it err
// is tied low.
// -----------------------------------------------------------------------------
module inert_ctrl
   import inert_pkg::*;
#(
   parameter int PWRUP_W = 16,
   parameter int TMO_W   = 12
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         INT,
   inert_ctrl_if.master spi,
   output logic [15:0]  yaw_rt,
   output logic         vld,
   output logic         cfg_done,
   output logic         err,
   output inert_state_t state
);

   inert_state_t       state_q, state_d;
   logic [PWRUP_W-1:0] pwr_cnt_q, pwr_cnt_d;
   logic [1:0]         idx_q, idx_d;
   logic               int_pend_q, int_pend_d;
   logic               spi_done_q, spi_done_d;
   logic [7:0]         low_q, low_d;
   logic [15:0]        yaw_q, yaw_d;
   logic               vld_q, vld_d;
   logic               cfg_done_q, cfg_done_d;
   logic               spi_wrt_q, spi_wrt_d;
   logic [15:0]        spi_cmd_q, spi_cmd_d;

   logic int_rise;
   logic done_rise;
   logic tmo_hit;
   logic tmo_abort;

   inert_int_sync u_int_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (INT),
      .rise     (int_rise)
   );

   // Completion is the rising edge only; a done level left high by the
   // previous transfer must not advance the sequencer.
   assign done_rise = spi.spi_done & ~spi_done_q;

   always_comb begin
      state_d    = state_q;
      pwr_cnt_d  = pwr_cnt_q;
      idx_d      = idx_q;
      low_d      = low_q;
      yaw_d      = yaw_q;
      vld_d      = 1'b0;
      cfg_done_d = cfg_done_q;
      spi_done_d = spi.spi_done;
      tmo_abort  = 1'b0;

      case (state_q)
         PWRUP: begin
            pwr_cnt_d = pwr_cnt_q + PWRUP_W'(1);
            if (pwr_cnt_q == '1) state_d = CFG;
         end
         CFG: state_d = CFG_W;
         CFG_W: begin
            if (done_rise) begin
               if (idx_q == 2'(NUM_CFG - 1)) begin
                  cfg_done_d = 1'b1;
                  state_d    = IDLE;
               end else begin
                  idx_d   = idx_q + 2'd1;
                  state_d = CFG;
               end
            end else if (tmo_hit) begin
               // retry the same table entry
               tmo_abort = 1'b1;
               state_d   = CFG;
            end
         end
         IDLE: begin
            if (int_pend_q) state_d = RD_L;
         end
         RD_L: state_d = RD_L_W;
         RD_L_W: begin
            if (done_rise) begin
               low_d   = spi.spi_rd_data[7:0];
               state_d = RD_H;
            end else if (tmo_hit) begin
               tmo_abort = 1'b1;
               state_d   = IDLE;
            end
         end
         RD_H: state_d = RD_H_W;
         RD_H_W: begin
            if (done_rise) begin
               // yaw_rt only ever moves together with vld
               yaw_d   = {spi.spi_rd_data[7:0], low_q};
               vld_d   = 1'b1;
               state_d = IDLE;
            end else if (tmo_hit) begin
               tmo_abort = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = PWRUP;
      endcase

      // Start pulse and command word are registered together on entry to a
      // command state, so the command is stable from the start pulse onward.
      spi_wrt_d = (state_d == CFG) || (state_d == RD_L) || (state_d == RD_H);
      spi_cmd_d = spi_cmd_q;
      case (state_d)
         CFG:     spi_cmd_d = cfg_cmd(idx_d);
         RD_L:    spi_cmd_d = CMD_YL;
         RD_H:    spi_cmd_d = CMD_YH;
         default: spi_cmd_d = spi_cmd_q;
      endcase

      // Rises before configuration completes are dropped. A rise arriving
      // during a read re-arms the pending flag, so any number of rises during
      // one read collapse into a single follow-up read.
      if (!cfg_done_q) begin
         int_pend_d = 1'b0;
      end else if (int_rise) begin
         int_pend_d = 1'b1;
      end else if ((state_q == IDLE) && (state_d == RD_L)) begin
         int_pend_d = 1'b0;
      end else begin
         int_pend_d = int_pend_q;
      end
   end

`ifdef INERT_TMO_EN
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             err_q, err_d;

   always_comb begin
      tmo_d = tmo_q;
      if (spi_wrt_d) begin
         tmo_d = '0;
      end else if ((state_q == CFG_W) || (state_q == RD_L_W) || (state_q == RD_H_W)) begin
         tmo_d = tmo_q + TMO_W'(1);
      end
      err_d = err_q | tmo_abort;
   end

   assign tmo_hit = (tmo_q == '1);
   assign err     = err_q;
`else
   logic unused_tmo_abort;
   localparam int unused_tmo_w = TMO_W;

   assign tmo_hit          = 1'b0;
   assign unused_tmo_abort = tmo_abort;
   assign err              = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= PWRUP;
         pwr_cnt_q  <= '0;
         idx_q      <= 2'd0;
         int_pend_q <= 1'b0;
         spi_done_q <= 1'b0;
         low_q      <= 8'h00;
         yaw_q      <= 16'h0000;
         vld_q      <= 1'b0;
         cfg_done_q <= 1'b0;
         spi_wrt_q  <= 1'b0;
         spi_cmd_q  <= 16'h0000;
`ifdef INERT_TMO_EN
         tmo_q      <= '0;
         err_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         pwr_cnt_q  <= pwr_cnt_d;
         idx_q      <= idx_d;
         int_pend_q <= int_pend_d;
         spi_done_q <= spi_done_d;
         low_q      <= low_d;
         yaw_q      <= yaw_d;
         vld_q      <= vld_d;
         cfg_done_q <= cfg_done_d;
         spi_wrt_q  <= spi_wrt_d;
         spi_cmd_q  <= spi_cmd_d;
`ifdef INERT_TMO_EN
         tmo_q      <= tmo_d;
         err_q      <= err_d;
`endif
      end
   end

   assign spi.spi_wrt = spi_wrt_q;
   assign spi.spi_cmd = spi_cmd_q;
   assign yaw_rt      = yaw_q;
   assign vld         = vld_q;
   assign cfg_done    = cfg_done_q;
   assign state       = state_q;

endmodule

// File: doc/inert_ctrl.md
Name: inert_ctrl

Overview:
- Sequencer for the SPI monarch that talks to the inertial sensor.
- After reset it waits for sensor power-up, then writes the configuration registers.
- It then services each sensor data-ready interrupt by reading yaw-rate low and high bytes, and presents a 16-bit yaw rate with a one-cycle valid pulse.
- It is the only requester driving the SPI monarch's wrt/wt_data.

Parameters:
- PWRUP_W, 16: width of the power-up wait counter; the first command issues 2^PWRUP_W clocks after reset release.
- TMO_W, 12: width of the transaction watchdog counter; used only with INERT_TMO_EN.

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  reset
- INT  in  1  sensor data-ready, asynchronous, active-high
- spi_done  in  1  SPI monarch done (level; clears on wrt, sets at end of transaction)
- spi_rd_data  in  16  SPI monarch read data; only [7:0] used
- spi_wrt  out  1  one-cycle transaction start pulse
- spi_cmd  out  16  command word to SPI monarch wt_data
- yaw_rt  out  16  signed yaw rate, {high byte, low byte}
- vld  out  1  one-cycle pulse, yaw_rt updated
- cfg_done  out  1  level; configuration complete
- err  out  1  sticky watchdog error flag

Behaviour:
- Reset is asynchronous, active-low, on rst_n; clock is clk.
- Reset values: spi_wrt=0, spi_cmd=16'h0000, yaw_rt=16'h0000, vld=0, cfg_done=0, err=0, state=PWRUP, all counters 0, int_pend=0.
- INT path: double-flop synchronised, then rising-edge detected.
  - A rise sets int_pend.
  - int_pend clears when the state machine leaves IDLE to begin a read.
  - A rise during an active read re-sets int_pend, so exactly one further read is serviced; multiple rises coalesce.
- Completion is the rising edge of spi_done (spi_done & ~spi_done_q, registered previous value). A stale high level never counts.
- spi_cmd is registered. It is loaded in the same cycle spi_wrt is asserted and held stable until completion.
- Configuration table, issued in order by a 2-bit index:
  - 0: 16'h0D02 (INT on gyro data ready)
  - 1: 16'h1160 (gyro ODR 416 Hz)
  - 2: 16'h1440 (rounding)
- Read commands:
  - YL = 16'hA600 (reg 0x26 | read)
  - YH = 16'hA700
- States:
  - PWRUP: counter increments; on all-ones go to CFG.
  - CFG: assert spi_wrt and spi_cmd=table[idx]; go to CFG_W.
  - CFG_W: on completion, if idx==2 set cfg_done and go to IDLE; else idx++ and go to CFG.
  - IDLE: if int_pend, go to RD_L.
  - RD_L: spi_wrt, cmd YL; go to RD_L_W.
  - RD_L_W: on completion, capture spi_rd_data[7:0] into a low-byte holding register; go to RD_H.
  - RD_H: spi_wrt, cmd YH; go to RD_H_W.
  - RD_H_W: on completion, yaw_rt <= {spi_rd_data[7:0], low_hold}; vld=1 in the following cycle; go to IDLE.
- Latency: INT rise to vld is 2 sync cycles + edge detect + 2 SPI transactions + 1 cycle.
- yaw_rt changes only together with vld. A partial read never updates yaw_rt.
- INT rises before cfg_done are ignored; int_pend is held clear until IDLE is first entered.
- Reset mid-transaction returns to PWRUP and repeats the full configuration.
- spi_wrt is never asserted while a transaction is outstanding.

Optional Feature:
- Macro INERT_TMO_EN.
- Defined:
  - In every *_W state a TMO_W-bit counter runs.
  - If it reaches all-ones before completion: set err (sticky until reset), abandon the transaction, and go to IDLE (config states go back to CFG with the same idx).
  - The counter clears on every spi_wrt.
  - yaw_rt is not updated on abort.
- Undefined: no counter logic; err tied 0.

Decomposition:
- Package inert_pkg:
  - state enum inert_state_t
  - CFG_CMD0..2, CMD_YL, CMD_YH localparams
  - NUM_CFG=3
- Sub-module inert_int_sync: 2-FF synchroniser plus rise detect, output int_rise. It is reusable for other async sensor strobes.

Test Plan:
- Reset release with PWRUP_W=4 -> first spi_wrt at cycle 16. Commands 0D02, 1160, 1440 in order, each only after a spi_done rise; cfg_done high after the third.
- INT pulse with the SPI model returning 8'h34 then 8'h12 -> cmds A600, A700; yaw_rt=16'h1234; vld high exactly 1 cycle.
- Three INT pulses during one read -> exactly one extra read pair and two vld pulses total. Pulses before cfg_done produce no read.
- spi_done held high from the previous transaction -> no premature advance; spi_cmd stable from wrt to done rise.
- rst_n low while in RD_H_W -> all outputs at reset values asynchronously; full config repeats; yaw_rt stays 0 until the next complete pair.
- INERT_TMO_EN, TMO_W=4, spi_done never rises in RD_L_W -> err set after 15 cycles, return to IDLE, yaw_rt unchanged; the next INT reads normally.
